// File: rtl/exception_sequencer.sv
// Exception sequencer: saves EPC, fetches the exception-vector word and loads the handler address into the PC.
// Optional Cause register built only when EXC_CAUSE_REG_EN is defined.
module exception_sequencer #(
   parameter logic [31:0] VEC_ADDR = 32'd252,
   parameter int          MEM_LAT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        overflow,
   input  logic        bad_opcode,
   input  logic [31:0] pc_in,
   input  logic [31:0] mem_data,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic [31:0] epc,
   output logic [31:0] new_pc,
   output logic        pc_load,
   output logic        busy,
   output logic [31:0] cause
);

   typedef enum logic [2:0] {IDLE, SAVE, FETCH, WAIT, LOAD} state_t;

   localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

   state_t      state, state_nxt;
   logic [2:0]  cnt;
   logic        ev_ovf;
   logic [31:0] handler;
   logic        mem_data_unused;

   assign mem_data_unused = ^mem_data[31:16];
   assign handler = ev_ovf ? {24'b0, mem_data[7:0]} : {24'b0, mem_data[15:8]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (overflow || bad_opcode) state_nxt = SAVE;
         SAVE:    state_nxt = FETCH;
         FETCH:   state_nxt = WAIT;
         WAIT:    if (cnt == 3'd0) state_nxt = LOAD;
         LOAD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      mem_rd   = (state == FETCH);
      mem_addr = (state == FETCH) ? VEC_ADDR : 32'd0;
      pc_load  = (state == LOAD);
   end

   // The handler byte is captured on the edge that enters LOAD, so new_pc is
   // already valid during the single cycle that pc_load is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ev_ovf <= 1'b0;
         cnt    <= 3'd0;
         epc    <= 32'd0;
         new_pc <= 32'd0;
      end else begin
         case (state)
            IDLE:  if (overflow || bad_opcode) ev_ovf <= overflow;
            SAVE:  epc <= pc_in - 32'd4;
            FETCH: cnt <= CNT_INIT;
            WAIT:  begin
               if (cnt != 3'd0) cnt <= cnt - 3'd1;
               else             new_pc <= handler;
            end
            default: ;
         endcase
      end
   end

`ifdef EXC_CAUSE_REG_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              cause <= 32'd0;
      else if (state == SAVE)  cause <= ev_ovf ? 32'd12 : 32'd10;
   end
`else
   assign cause = 32'd0;
`endif

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: two instances (MEM_LAT=2 and MEM_LAT=1) against a transaction-offset model.
// Cause expectations follow EXC_CAUSE_REG_EN.
module tb_exception_sequencer;

   logic        clk = 1'b0;
   logic        reset, overflow, bad_opcode;
   logic [31:0] pc_in, mem_data;
   logic [31:0] mem_addr0, epc0, new_pc0, cause0, mem_addr1, epc1, new_pc1, cause1;
   logic        mem_rd0, pc_load0, busy0, mem_rd1, pc_load1, busy1;

   always #5 clk = ~clk;

   exception_sequencer #(.VEC_ADDR(32'd252), .MEM_LAT(2)) dut0 (
      .clk(clk), .reset(reset), .overflow(overflow), .bad_opcode(bad_opcode),
      .pc_in(pc_in), .mem_data(mem_data), .mem_addr(mem_addr0), .mem_rd(mem_rd0),
      .epc(epc0), .new_pc(new_pc0), .pc_load(pc_load0), .busy(busy0), .cause(cause0));

   exception_sequencer #(.VEC_ADDR(32'd252), .MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .overflow(overflow), .bad_opcode(bad_opcode),
      .pc_in(pc_in), .mem_data(mem_data), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
      .epc(epc1), .new_pc(new_pc1), .pc_load(pc_load1), .busy(busy1), .cause(cause1));

   int vectors = 0;
   int miscompares = 0;

   // Model: an accepted trigger in cycle t0 makes cycle t0+k behave as
   // k=1 save, k=2 fetch, k=3..L+2 wait, k=L+3 load.
   int          lat [2] = '{2, 1};
   bit          act [2];
   int          t0  [2];
   bit          movf[2];
   logic [31:0] mepc[2], mnpc[2], mcause[2];
   int          cyc = 0;
   bit          pl[2], bz[2];

   typedef struct {
      bit          ov;
      bit          bo;
      logic [31:0] pc;
      logic [31:0] md;
      logic [31:0] e_epc;
      logic [31:0] e_npc;
      logic [31:0] e_cause;
   } vec_t;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_cause(input logic [31:0] c);
`ifdef EXC_CAUSE_REG_EN
      return c;
`else
      return 32'd0 & c;
`endif
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; mepc[i] = '0; mnpc[i] = '0; mcause[i] = '0; movf[i] = 1'b0; t0[i] = 0;
      end
   endtask

   task automatic check_cycle();
      int k;
      bit e_busy, e_rd, e_pl;
      logic [31:0] a_addr, a_epc, a_npc, a_cause;
      logic a_rd, a_pl, a_busy;
      string nm;
      if (!reset) model_clear();
      for (int i = 0; i < 2; i++) begin
         nm = (i == 0) ? "dut0" : "dut1";
         if (i == 0) begin
            a_addr = mem_addr0; a_epc = epc0; a_npc = new_pc0; a_cause = cause0;
            a_rd = mem_rd0; a_pl = pc_load0; a_busy = busy0;
         end else begin
            a_addr = mem_addr1; a_epc = epc1; a_npc = new_pc1; a_cause = cause1;
            a_rd = mem_rd1; a_pl = pc_load1; a_busy = busy1;
         end
         k      = cyc - t0[i];
         e_busy = act[i] && k >= 1 && k <= lat[i] + 3;
         e_rd   = act[i] && k == 2;
         e_pl   = act[i] && k == lat[i] + 3;
         cmp({nm, ".busy"},     {31'd0, a_busy}, {31'd0, e_busy});
         cmp({nm, ".mem_rd"},   {31'd0, a_rd},   {31'd0, e_rd});
         cmp({nm, ".mem_addr"}, a_addr,          e_rd ? 32'd252 : 32'd0);
         cmp({nm, ".pc_load"},  {31'd0, a_pl},   {31'd0, e_pl});
         cmp({nm, ".epc"},      a_epc,           mepc[i]);
         cmp({nm, ".new_pc"},   a_npc,           mnpc[i]);
         cmp({nm, ".cause"},    a_cause,         exp_cause(mcause[i]));
         pl[i] = a_pl;
         bz[i] = a_busy;
         if (reset) begin
            if (act[i] && k == 1) begin
               mepc[i]   = pc_in - 32'd4;
               mcause[i] = movf[i] ? 32'd12 : 32'd10;
            end
            if (act[i] && k == lat[i] + 2)
               mnpc[i] = movf[i] ? {24'b0, mem_data[7:0]} : {24'b0, mem_data[15:8]};
            if (act[i] && k == lat[i] + 3) act[i] = 1'b0;
            if (!e_busy && (overflow || bad_opcode)) begin
               act[i]  = 1'b1;
               t0[i]   = cyc;
               movf[i] = overflow;
            end
         end
      end
      cyc++;
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((act[0] || act[1]) && n < 30) begin
         step();
         n++;
      end
      if (act[0] || act[1]) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      cmp("async_reset.busy0",    {31'd0, busy0},    32'd0);
      cmp("async_reset.pc_load0", {31'd0, pc_load0}, 32'd0);
      cmp("async_reset.epc0",     epc0,              32'd0);
      cmp("async_reset.new_pc1",  new_pc1,           32'd0);
      step();
      step();
      reset = 1'b1;
   endtask

   vec_t tbl[5];
   int   l0, l1, p0, p1;

   initial begin
      tbl[0] = '{1'b1, 1'b0, 32'h40,  32'h0000_5A3C, 32'h3C,       32'h3C, 32'd12};
      tbl[1] = '{1'b0, 1'b1, 32'h40,  32'h0000_5A3C, 32'h3C,       32'h5A, 32'd10};
      tbl[2] = '{1'b1, 1'b1, 32'h40,  32'h0000_5A3C, 32'h3C,       32'h3C, 32'd12};
      tbl[3] = '{1'b1, 1'b0, 32'h0,   32'h1234_56FF, 32'hFFFFFFFC, 32'hFF, 32'd12};
      tbl[4] = '{1'b0, 1'b1, 32'h100, 32'h0000_AB00, 32'hFC,       32'hAB, 32'd10};

      reset = 1'b1; overflow = 1'b0; bad_opcode = 1'b0; pc_in = '0; mem_data = '0;
      model_clear();
      #1 reset = 1'b0;
      step();
      step();
      cmp("reset.cause0",    cause0,    32'd0);
      cmp("reset.mem_addr0", mem_addr0, 32'd0);
      reset = 1'b1;
      step();

      // Directed table: final values plus trigger-to-pc_load latency
      foreach (tbl[v]) begin
         wait_idle();
         pc_in = tbl[v].pc; mem_data = tbl[v].md;
         overflow = tbl[v].ov; bad_opcode = tbl[v].bo;
         step();
         overflow = 1'b0; bad_opcode = 1'b0;
         l0 = -1; l1 = -1;
         for (int j = 1; j <= 10; j++) begin
            step();
            if (pl[0] && l0 < 0) l0 = j;
            if (pl[1] && l1 < 0) l1 = j;
         end
         cmp($sformatf("tbl%0d.latency0", v), 32'(l0), 32'd5);
         cmp($sformatf("tbl%0d.latency1", v), 32'(l1), 32'd4);
         cmp($sformatf("tbl%0d.epc0", v),    epc0,    tbl[v].e_epc);
         cmp($sformatf("tbl%0d.new_pc0", v), new_pc0, tbl[v].e_npc);
         cmp($sformatf("tbl%0d.cause0", v),  cause0,  exp_cause(tbl[v].e_cause));
         cmp($sformatf("tbl%0d.epc1", v),    epc1,    tbl[v].e_epc);
         cmp($sformatf("tbl%0d.new_pc1", v), new_pc1, tbl[v].e_npc);
      end

      // Second overflow during WAIT is dropped
      wait_idle();
      pc_in = 32'h40; mem_data = 32'h0000_5A3C; overflow = 1'b1;
      step();
      overflow = 1'b0;
      p0 = 0; p1 = 0;
      for (int j = 1; j <= 12; j++) begin
         if (j == 3) begin overflow = 1'b1; pc_in = 32'h999; end
         if (j == 4) overflow = 1'b0;
         step();
         p0 += int'(pl[0]);
         p1 += int'(pl[1]);
      end
      cmp("wait_retrigger.pulses0", 32'(p0), 32'd1);
      cmp("wait_retrigger.pulses1", 32'(p1), 32'd1);
      cmp("wait_retrigger.epc0",    epc0,    32'h3C);

      // Reset in WAIT aborts with no pc_load, then a fresh trigger completes
      wait_idle();
      pc_in = 32'h40; overflow = 1'b1;
      step();
      overflow = 1'b0;
      step();
      step();
      do_reset();
      p0 = 0; p1 = 0;
      for (int j = 0; j < 8; j++) begin
         step();
         p0 += int'(pl[0]);
         p1 += int'(pl[1]);
      end
      cmp("reset_abort.pulses0", 32'(p0), 32'd0);
      cmp("reset_abort.pulses1", 32'(p1), 32'd0);
      bad_opcode = 1'b1;
      step();
      bad_opcode = 1'b0;
      wait_idle();
      cmp("after_reset.new_pc0", new_pc0, 32'h5A);
      cmp("after_reset.epc0",    epc0,    32'h3C);

      // Trigger during the pc_load cycle waits for the next IDLE cycle
      wait_idle();
      overflow = 1'b1;
      step();
      overflow = 1'b0;
      for (int j = 1; j <= 4; j++) step();
      overflow = 1'b1; pc_in = 32'h80;
      step();
      cmp("load_trigger.pc_load0", {31'd0, pl[0]}, 32'd1);
      step();
      cmp("load_trigger.idle0", {31'd0, bz[0]}, 32'd0);
      overflow = 1'b0;
      step();
      cmp("load_trigger.busy0", {31'd0, bz[0]}, 32'd1);
      wait_idle();
      cmp("load_trigger.epc0", epc0, 32'h7C);
      cmp("load_trigger.epc1", epc1, 32'h7C);

      // Randomized traffic, including occasional resets
      for (int n = 0; n < 3000; n++) begin
         overflow   = ($urandom_range(9) == 0);
         bad_opcode = ($urandom_range(9) == 0);
         if ($urandom_range(3) == 0) pc_in = $urandom;
         if (!act[0] && !act[1] && $urandom_range(2) == 0) mem_data = $urandom;
         if ($urandom_range(199) == 0) do_reset();
         else step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
